// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a standard-read FIFO port (empty/rd_en, data READ_LATENCY
// cycles later) into a valid/ready stream through a small skid buffer.
// Ports: clk, rst (async, active-high), flush (sync drop of buffered/in-flight words);
//   FIFO side: fifo_empty, fifo_dout, fifo_rderr in, fifo_rd_en out;
//   stream side: m_data, m_valid out, m_ready in; level = buffered words; err = sticky error.
module fifo_rd_stream #(
  parameter int WIDTH        = 9,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_rderr,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [1:0]       level,
  output logic             err
);

  localparam int BUF_DEPTH = READ_LATENCY + 1;

  typedef logic [1:0]              ptr_t;
  typedef logic [READ_LATENCY-1:0] pipe_t;

  // Storage spans the full pointer range; entries at or past
  // BUF_DEPTH are never written because the pointers wrap earlier.
  logic [WIDTH-1:0] buf_q [4];

  ptr_t  rd_ptr_q, rd_ptr_d;
  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  count_q, count_d;
  pipe_t pipe_q, pipe_d;
  pipe_t squash_q, squash_d;
  logic  err_q, err_d;

  ptr_t       inflight;
  logic [2:0] occ;
  logic       capture;
  logic       pop;

  function automatic ptr_t wrap_inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + 2'd1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++)
      inflight = inflight + ptr_t'(pipe_q[i]);
  end

  // Reserve a buffer slot for every word already requested, so a
  // read is only issued when it can land even if m_ready stays low.
  assign occ        = {1'b0, count_q} + {1'b0, inflight};
  assign fifo_rd_en = !rst && !flush && !fifo_empty
                      && (occ < 3'(BUF_DEPTH));

  assign m_valid = (count_q != '0);
  assign m_data  = buf_q[rd_ptr_q];
  assign level   = count_q;
  assign err     = err_q;

  assign capture = pipe_q[READ_LATENCY-1]
                   && !squash_q[READ_LATENCY-1] && !flush;
  assign pop     = m_valid && m_ready && !flush;

  always_comb begin
    pipe_d   = (pipe_q << 1) | pipe_t'(fifo_rd_en);
    // On flush every word still travelling through the read
    // latency is marked so it is dropped when it arrives.
    squash_d = flush ? (pipe_q << 1) : (squash_q << 1);
    rd_ptr_d = pop ? wrap_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = capture ? wrap_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q + ptr_t'(capture) - ptr_t'(pop);
    err_d    = err_q | fifo_rderr;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pipe_q   <= '0;
      squash_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < 4; i++)
        buf_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pipe_q   <= pipe_d;
      squash_q <= squash_d;
      err_q    <= err_d;
      if (capture)
        buf_q[wr_ptr_q] <= fifo_dout;
    end
  end

endmodule
